// File: rtl/inst_pkg.sv
// inst_pkg: shared format tags, opcodes and field bundle for the RV32I instruction encoder.
package inst_pkg;
   typedef enum logic [2:0] {
      FMT_R = 3'd0,
      FMT_I = 3'd1,
      FMT_S = 3'd2,
      FMT_B = 3'd3,
      FMT_U = 3'd4,
      FMT_J = 3'd5
   } inst_fmt_e;
   localparam logic [6:0] OP_IMM = 7'h13;
   localparam logic [6:0] LOAD   = 7'h03;
   localparam logic [6:0] JALR   = 7'h67;
   localparam logic [6:0] STORE  = 7'h23;
   localparam logic [6:0] BRANCH = 7'h63;
   localparam logic [6:0] AUIPC  = 7'h17;
   localparam logic [6:0] LUI    = 7'h37;
   localparam logic [6:0] JAL    = 7'h6F;
   localparam logic [31:0] NOP   = 32'h0000_0013;
   typedef struct packed {
      logic [6:0] opcode;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [2:0] funct3;
      logic [6:0] funct7;
   } inst_fields_t;
endpackage

// File: rtl/inst_encoder_if.sv
// inst_encoder_if: input stream, output stream, restart and error count of the encoder.
interface inst_encoder_if #(parameter int ERR_CNT_W = 8);
   logic                 restart;
   logic                 in_valid;
   logic                 in_ready;
   logic [2:0]           in_fmt;
   logic [6:0]           in_opcode;
   logic [4:0]           in_rd;
   logic [4:0]           in_rs1;
   logic [4:0]           in_rs2;
   logic [2:0]           in_funct3;
   logic [6:0]           in_funct7;
   logic [31:0]          in_imm;
   logic                 out_valid;
   logic                 out_ready;
   logic [31:0]          out_inst;
   logic [31:0]          out_addr;
   logic                 out_err;
   logic [ERR_CNT_W-1:0] err_count;
   modport slave (
      input  restart, in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, out_ready,
      output in_ready, out_valid, out_inst, out_addr, out_err, err_count
   );
   modport master (
      output restart, in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, out_ready,
      input  in_ready, out_valid, out_inst, out_addr, out_err, err_count
   );
endinterface

// File: rtl/inst_encoder_field_pack.sv
// inst_field_pack: range/alignment check and bit scatter of one RV32I instruction.
module inst_field_pack
   import inst_pkg::*;
(
   input  logic [2:0]   fmt,
   input  inst_fields_t f,
   input  logic [31:0]  imm,
   output logic [31:0]  inst,
   output logic         err
);
   logic i_ok, b_ok, u_ok, j_ok, bad;
   logic [31:0] raw;
   assign i_ok = &imm[31:11] || ~|imm[31:11];
   assign b_ok = (&imm[31:12] || ~|imm[31:12]) && !imm[0];
   assign u_ok = ~|imm[11:0];
   assign j_ok = (&imm[31:20] || ~|imm[31:20]) && !imm[0];
   always_comb begin
      raw = 32'h0;
      bad = 1'b1;
      case (fmt)
         FMT_R: begin raw = {f.funct7, f.rs2, f.rs1, f.funct3, f.rd, f.opcode}; bad = 1'b0; end
         FMT_I: begin raw = {imm[11:0], f.rs1, f.funct3, f.rd, f.opcode}; bad = !i_ok; end
         FMT_S: begin raw = {imm[11:5], f.rs2, f.rs1, f.funct3, imm[4:0], f.opcode}; bad = !i_ok; end
         FMT_B: begin raw = {imm[12], imm[10:5], f.rs2, f.rs1, f.funct3, imm[4:1], imm[11], f.opcode}; bad = !b_ok; end
         FMT_U: begin raw = {imm[31:12], f.rd, f.opcode}; bad = !u_ok; end
         FMT_J: begin raw = {imm[20], imm[10:1], imm[11], imm[19:12], f.rd, f.opcode}; bad = !j_ok; end
         default: begin raw = 32'h0; bad = 1'b1; end
      endcase
   end
   // rejected words are emitted as all-zero so a stray write cannot look like code
   assign err  = bad || (f.opcode[1:0] != 2'b11);
   assign inst = err ? 32'h0 : raw;
endmodule

// File: rtl/inst_encoder.sv
// inst_encoder: two-stage RV32I encoder with word address counter and saturating error count.
module inst_encoder
   import inst_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          ERR_CNT_W = 8
) (
   input logic           clk,
   input logic           rst_n,
   inst_encoder_if.slave bus
);
   logic                 rdy_q, rdy_d;
   logic                 s1_v_q, s1_v_d;
   logic [2:0]           s1_fmt_q, s1_fmt_d;
   inst_fields_t         s1_f_q, s1_f_d;
   logic [31:0]          s1_imm_q, s1_imm_d;
   logic                 s2_v_q, s2_v_d;
   logic [31:0]          s2_inst_q, s2_inst_d;
   logic [31:0]          s2_addr_q, s2_addr_d;
   logic                 s2_err_q, s2_err_d;
   logic [31:0]          addr_q, addr_d;
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic [31:0]          pk_inst;
   logic                 pk_err, s2_free, s1_adv, acc;
   inst_field_pack u_pack (.fmt(s1_fmt_q), .f(s1_f_q), .imm(s1_imm_q), .inst(pk_inst), .err(pk_err));
   assign s2_free       = !s2_v_q || bus.out_ready;
   assign s1_adv        = s1_v_q && s2_free;
   // rdy_q keeps in_ready low until the first edge after reset release
   assign bus.in_ready  = rdy_q && !bus.restart && (!s1_v_q || s2_free);
   assign acc           = bus.in_valid && bus.in_ready;
   assign bus.out_valid = s2_v_q;
   assign bus.out_inst  = s2_inst_q;
   assign bus.out_addr  = s2_addr_q;
   assign bus.out_err   = s2_err_q;
   assign bus.err_count = err_cnt_q;
   always_comb begin
      rdy_d     = 1'b1;
      s1_v_d    = bus.restart ? 1'b0 : acc ? 1'b1 : s1_adv ? 1'b0 : s1_v_q;
      s1_fmt_d  = acc ? bus.in_fmt : s1_fmt_q;
      s1_f_d    = acc ? inst_fields_t'{opcode: bus.in_opcode, rd: bus.in_rd, rs1: bus.in_rs1, rs2: bus.in_rs2,
                                       funct3: bus.in_funct3, funct7: bus.in_funct7} : s1_f_q;
      s1_imm_d  = acc ? bus.in_imm : s1_imm_q;
      s2_v_d    = bus.restart ? 1'b0 : s1_adv ? 1'b1 : bus.out_ready ? 1'b0 : s2_v_q;
      s2_inst_d = s1_adv ? pk_inst : s2_inst_q;
      s2_addr_d = s1_adv ? addr_q : s2_addr_q;
      s2_err_d  = s1_adv ? pk_err : s2_err_q;
      addr_d    = bus.restart ? BASE_ADDR : (s1_adv && !pk_err) ? addr_q + 32'd4 : addr_q;
      err_cnt_d = (s2_v_q && bus.out_ready && s2_err_q && !(&err_cnt_q)) ? err_cnt_q + 1'b1 : err_cnt_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy_q     <= 1'b0;
         s1_v_q    <= 1'b0;
         s1_fmt_q  <= 3'd0;
         s1_f_q    <= '0;
         s1_imm_q  <= 32'h0;
         s2_v_q    <= 1'b0;
         s2_inst_q <= 32'h0;
         s2_addr_q <= 32'h0;
         s2_err_q  <= 1'b0;
         addr_q    <= BASE_ADDR;
         err_cnt_q <= '0;
      end else begin
         rdy_q     <= rdy_d;
         s1_v_q    <= s1_v_d;
         s1_fmt_q  <= s1_fmt_d;
         s1_f_q    <= s1_f_d;
         s1_imm_q  <= s1_imm_d;
         s2_v_q    <= s2_v_d;
         s2_inst_q <= s2_inst_d;
         s2_addr_q <= s2_addr_d;
         s2_err_q  <= s2_err_d;
         addr_q    <= addr_d;
         err_cnt_q <= err_cnt_d;
      end
   end
endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: directed scenarios for the RV32I encoder with hand-computed expectations.
module tb_inst_encoder;
   import inst_pkg::*;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int total = 0;
   int bad = 0;
   logic [31:0] exp_addr = 32'h0;
   int exp_err = 0;
   inst_encoder_if #(.ERR_CNT_W(8)) b ();
   inst_encoder #(.BASE_ADDR(32'h0000_0000), .ERR_CNT_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(b));
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      b.in_valid = 1'b0;
      b.out_ready = 1'b1;
      repeat (n) step();
   endtask

   task automatic send_one(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                           output logic [31:0] inst, output logic [31:0] addr, output logic err, output int lat);
      int n = 0;
      b.out_ready = 1'b1;
      b.in_fmt = fmt; b.in_opcode = op; b.in_rd = rd; b.in_rs1 = rs1; b.in_rs2 = rs2;
      b.in_funct3 = f3; b.in_funct7 = f7; b.in_imm = imm; b.in_valid = 1'b1;
      while (!b.in_ready && n < 20) begin step(); n++; end
      step();
      b.in_valid = 1'b0;
      lat = 0;
      while (!b.out_valid && lat < 20) begin step(); lat++; end
      inst = b.out_inst; addr = b.out_addr; err = b.out_err;
   endtask

   function automatic logic [31:0] dec_imm(input logic [2:0] fmt, input logic [31:0] i);
      case (fmt)
         3'd1: return {{20{i[31]}}, i[31:20]};
         3'd2: return {{20{i[31]}}, i[31:25], i[11:7]};
         3'd3: return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
         3'd4: return {i[31:12], 12'h0};
         3'd5: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
         default: return 32'h0;
      endcase
   endfunction

   task automatic test_reset();
      b.restart = 1'b0; b.in_valid = 1'b0; b.out_ready = 1'b1;
      b.in_fmt = 3'd0; b.in_opcode = 7'h0; b.in_rd = 5'd0; b.in_rs1 = 5'd0; b.in_rs2 = 5'd0;
      b.in_funct3 = 3'd0; b.in_funct7 = 7'd0; b.in_imm = 32'h0;
      #3;
      total++;
      if (b.out_valid !== 1'b0 || b.out_inst !== 32'h0 || b.out_addr !== 32'h0 || b.out_err !== 1'b0 || b.err_count !== 8'd0) begin
         bad++; $display("FAIL reset_outputs got v=%b inst=%h addr=%h err=%b cnt=%0d exp all zero", b.out_valid, b.out_inst, b.out_addr, b.out_err, b.err_count);
      end
      total++;
      if (b.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", b.in_ready); end
      #9 rst_n = 1'b1;
      #1;
      total++;
      if (b.in_ready !== 1'b0) begin bad++; $display("FAIL release_in_ready got=%b exp=0", b.in_ready); end
      step();
      total++;
      if (b.in_ready !== 1'b1) begin bad++; $display("FAIL first_edge_in_ready got=%b exp=1", b.in_ready); end
   endtask

   task automatic test_i_type();
      logic [31:0] inst, addr; logic err; int lat;
      send_one(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, inst, addr, err, lat);
      total++;
      if (inst !== 32'hFFF00093 || addr !== exp_addr || err !== 1'b0) begin
         bad++; $display("FAIL i_type got inst=%h addr=%h err=%b exp inst=FFF00093 addr=%h err=0", inst, addr, err, exp_addr);
      end
      total++;
      if (lat !== 1) begin bad++; $display("FAIL i_latency got=%0d exp=1", lat); end
      exp_addr += 4;
      send_one(FMT_I, OP_IMM, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0, inst, addr, err, lat);
      total++;
      if (inst !== NOP || addr !== exp_addr) begin bad++; $display("FAIL i_next_addr got inst=%h addr=%h exp inst=%h addr=%h", inst, addr, NOP, exp_addr); end
      exp_addr += 4;
   endtask

   task automatic test_b_type();
      logic [31:0] inst, addr; logic err; int lat;
      send_one(FMT_B, BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC, inst, addr, err, lat);
      total++;
      if (inst !== 32'hFE208EE3 || addr !== exp_addr || err !== 1'b0) begin
         bad++; $display("FAIL b_type got inst=%h addr=%h err=%b exp inst=FE208EE3 addr=%h err=0", inst, addr, err, exp_addr);
      end
      exp_addr += 4;
      send_one(FMT_B, BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3, inst, addr, err, lat);
      total++;
      if (inst !== 32'h0 || addr !== exp_addr || err !== 1'b1) begin
         bad++; $display("FAIL b_misaligned got inst=%h addr=%h err=%b exp inst=0 addr=%h err=1", inst, addr, err, exp_addr);
      end
      idle(1);
      exp_err++;
      total++;
      if (b.err_count !== 8'(exp_err)) begin bad++; $display("FAIL b_err_count got=%0d exp=%0d", b.err_count, exp_err); end
   endtask

   task automatic test_uj();
      logic [31:0] inst, addr; logic err; int lat;
      send_one(FMT_U, LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, inst, addr, err, lat);
      total++;
      if (inst !== 32'h123452B7 || addr !== exp_addr || err !== 1'b0) begin
         bad++; $display("FAIL lui got inst=%h addr=%h err=%b exp inst=123452B7 addr=%h err=0", inst, addr, err, exp_addr);
      end
      exp_addr += 4;
      send_one(FMT_J, JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, inst, addr, err, lat);
      total++;
      if (inst !== 32'h001000EF || addr !== exp_addr || err !== 1'b0) begin
         bad++; $display("FAIL jal got inst=%h addr=%h err=%b exp inst=001000EF addr=%h err=0", inst, addr, err, exp_addr);
      end
      exp_addr += 4;
      send_one(FMT_U, LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345001, inst, addr, err, lat);
      total++;
      if (inst !== 32'h0 || addr !== exp_addr || err !== 1'b1) begin
         bad++; $display("FAIL lui_low_bits got inst=%h addr=%h err=%b exp inst=0 addr=%h err=1", inst, addr, err, exp_addr);
      end
      send_one(FMT_R, 7'h32, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'h0, inst, addr, err, lat);
      total++;
      if (inst !== 32'h0 || err !== 1'b1) begin bad++; $display("FAIL bad_opcode got inst=%h err=%b exp inst=0 err=1", inst, err); end
      send_one(FMT_R, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hDEAD_BEEF, inst, addr, err, lat);
      total++;
      if (inst !== 32'h402081B3 || addr !== exp_addr || err !== 1'b0) begin
         bad++; $display("FAIL r_sub got inst=%h addr=%h err=%b exp inst=402081B3 addr=%h err=0", inst, addr, err, exp_addr);
      end
      exp_addr += 4;
      idle(1);
      exp_err += 2;
      total++;
      if (b.err_count !== 8'(exp_err)) begin bad++; $display("FAIL uj_err_count got=%0d exp=%0d", b.err_count, exp_err); end
   endtask

   task automatic test_backpressure();
      logic [31:0] exp_inst [6];
      logic [31:0] q_inst [$];
      logic [31:0] q_addr [$];
      logic [31:0] p_inst, p_addr, e_inst, e_addr;
      logic stall, acc, hs;
      int sent, got, occ, c;
      exp_inst[0] = 32'h00100093; exp_inst[1] = 32'h00200113; exp_inst[2] = 32'h00300193;
      exp_inst[3] = 32'h00400213; exp_inst[4] = 32'h00500293; exp_inst[5] = 32'h00600313;
      idle(2);
      sent = 0; got = 0; occ = 0; c = 0; stall = 1'b0; p_inst = 32'h0; p_addr = 32'h0;
      while (got < 6 && c < 60) begin
         if (stall) begin
            total++;
            if (b.out_valid !== 1'b1 || b.out_inst !== p_inst || b.out_addr !== p_addr) begin
               bad++; $display("FAIL bp_stable got v=%b inst=%h addr=%h exp v=1 inst=%h addr=%h", b.out_valid, b.out_inst, b.out_addr, p_inst, p_addr);
            end
         end
         b.out_ready = (c % 3 == 0);
         b.in_valid = (sent < 6);
         b.in_fmt = FMT_I; b.in_opcode = OP_IMM; b.in_rd = 5'(sent + 1); b.in_rs1 = 5'd0; b.in_rs2 = 5'd0;
         b.in_funct3 = 3'd0; b.in_funct7 = 7'd0; b.in_imm = 32'(sent + 1);
         #1;
         total++;
         if (b.in_ready !== !(occ == 2 && !b.out_ready)) begin
            bad++; $display("FAIL bp_in_ready cycle=%0d got=%b exp=%b", c, b.in_ready, !(occ == 2 && !b.out_ready));
         end
         acc = b.in_valid && b.in_ready;
         hs = b.out_valid && b.out_ready;
         if (hs) begin
            total++;
            e_inst = (q_inst.size() > 0) ? q_inst.pop_front() : 32'hX;
            e_addr = (q_addr.size() > 0) ? q_addr.pop_front() : 32'hX;
            if (b.out_inst !== e_inst || b.out_addr !== e_addr) begin
               bad++; $display("FAIL bp_order got inst=%h addr=%h exp inst=%h addr=%h", b.out_inst, b.out_addr, e_inst, e_addr);
            end
            got++;
         end
         if (acc) begin q_inst.push_back(exp_inst[sent]); q_addr.push_back(exp_addr); exp_addr += 4; sent++; end
         stall = b.out_valid && !b.out_ready;
         p_inst = b.out_inst; p_addr = b.out_addr;
         occ = occ + int'(acc) - int'(hs);
         step();
         c++;
      end
      total++;
      if (got != 6 || sent != 6) begin bad++; $display("FAIL bp_count got=%0d/%0d exp=6/6", got, sent); end
      idle(2);
      total++;
      if (b.out_valid !== 1'b0) begin bad++; $display("FAIL bp_no_duplicate got=%b exp=0", b.out_valid); end
   endtask

   task automatic test_restart();
      logic [31:0] inst, addr; logic err; int lat;
      idle(1);
      b.out_ready = 1'b0;
      b.in_fmt = FMT_I; b.in_opcode = OP_IMM; b.in_rs1 = 5'd0; b.in_rs2 = 5'd0;
      b.in_funct3 = 3'd0; b.in_funct7 = 7'd0; b.in_valid = 1'b1;
      b.in_rd = 5'd7; b.in_imm = 32'd7; step();
      b.in_rd = 5'd8; b.in_imm = 32'd8; step();
      b.in_rd = 5'd9; b.in_imm = 32'd9; b.restart = 1'b1;
      total++;
      if (b.in_ready !== 1'b0 || b.out_valid !== 1'b1) begin bad++; $display("FAIL restart_full got rdy=%b v=%b exp rdy=0 v=1", b.in_ready, b.out_valid); end
      step();
      b.restart = 1'b0; b.in_valid = 1'b0; b.out_ready = 1'b1;
      total++;
      if (b.out_valid !== 1'b0) begin bad++; $display("FAIL restart_flush got=%b exp=0", b.out_valid); end
      step();
      total++;
      if (b.out_valid !== 1'b0) begin bad++; $display("FAIL restart_not_accepted got=%b exp=0", b.out_valid); end
      total++;
      if (b.err_count !== 8'(exp_err)) begin bad++; $display("FAIL restart_err_count got=%0d exp=%0d", b.err_count, exp_err); end
      exp_addr = 32'h0;
      send_one(FMT_I, OP_IMM, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0, inst, addr, err, lat);
      total++;
      if (inst !== NOP || addr !== 32'h0) begin bad++; $display("FAIL restart_base got inst=%h addr=%h exp inst=%h addr=0", inst, addr, NOP); end
      exp_addr += 4;
   endtask

   task automatic test_roundtrip();
      logic [31:0] inst, addr, imm, r, d; logic err; int lat;
      logic [2:0] fmt; logic [6:0] op;
      for (int k = 0; k < 20; k++) begin
         r = $urandom;
         fmt = 3'(1 + k % 5);
         case (fmt)
            3'd1: begin op = OP_IMM; imm = {{20{r[11]}}, r[11:0]}; end
            3'd2: begin op = STORE;  imm = {{20{r[11]}}, r[11:0]}; end
            3'd3: begin op = BRANCH; imm = {{19{r[12]}}, r[12:1], 1'b0}; end
            3'd4: begin op = LUI;    imm = {r[31:12], 12'h0}; end
            default: begin op = JAL; imm = {{11{r[20]}}, r[20:1], 1'b0}; end
         endcase
         send_one(fmt, op, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'd0, imm, inst, addr, err, lat);
         d = dec_imm(fmt, inst);
         total++;
         if (d !== imm || err !== 1'b0 || addr !== exp_addr || inst[6:0] !== op) begin
            bad++; $display("FAIL roundtrip fmt=%0d got imm=%h err=%b addr=%h exp imm=%h err=0 addr=%h", fmt, d, err, addr, imm, exp_addr);
         end
         exp_addr += 4;
      end
   endtask

   task automatic test_err_saturation();
      logic [31:0] inst, addr; logic err; int lat;
      int n = 0, c = 0;
      idle(1);
      b.in_fmt = 3'd7; b.in_opcode = OP_IMM; b.in_imm = 32'h0; b.in_valid = 1'b1;
      while (n < 300 && c < 400) begin
         if (b.in_ready) n++;
         step();
         c++;
      end
      idle(3);
      total++;
      if (b.err_count !== 8'd255) begin bad++; $display("FAIL err_saturation got=%0d exp=255", b.err_count); end
      send_one(FMT_I, OP_IMM, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0, inst, addr, err, lat);
      total++;
      if (addr !== exp_addr || err !== 1'b0) begin bad++; $display("FAIL err_addr_hold got addr=%h err=%b exp addr=%h err=0", addr, err, exp_addr); end
      exp_addr += 4;
   endtask

   task automatic test_async_reset();
      logic [31:0] inst, addr; logic err; int lat;
      b.in_fmt = FMT_I; b.in_opcode = OP_IMM; b.in_imm = 32'h0; b.in_rd = 5'd0; b.in_valid = 1'b1;
      step();
      b.in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (b.out_valid !== 1'b0 || b.in_ready !== 1'b0 || b.err_count !== 8'd0) begin
         bad++; $display("FAIL async_reset got v=%b rdy=%b cnt=%0d exp 0 0 0", b.out_valid, b.in_ready, b.err_count);
      end
      step();
      total++;
      if (b.out_valid !== 1'b0) begin bad++; $display("FAIL reset_drops_word got=%b exp=0", b.out_valid); end
      rst_n = 1'b1;
      step();
      send_one(FMT_I, OP_IMM, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0, inst, addr, err, lat);
      total++;
      if (inst !== NOP || addr !== 32'h0) begin bad++; $display("FAIL post_reset_addr got inst=%h addr=%h exp inst=%h addr=0", inst, addr, NOP); end
   endtask

   initial begin
      test_reset();
      test_i_type();
      test_b_type();
      test_uj();
      test_backpressure();
      test_restart();
      test_roundtrip();
      test_err_saturation();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/inst_encoder.md
# inst_encoder

Pipelined RISC-V RV32I instruction encoder: the inverse of the core's immediate constructor. Accepts a format tag, opcode, register/function fields and a 32-bit immediate, checks the immediate for range and alignment, scatters its bits into the R/I/S/B/U/J layout, and streams encoded words with sequential word addresses. It sits between the test/boot program generator and the instruction-memory write port. It also produces encoder-golden streams for round-trip checks against the decoder.

## Interface
- BASE_ADDR, 32'h0000_0000: address attached to the first encoded word after reset/restart
- ERR_CNT_W, 8: width of the saturating error counter
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- restart  in  1  synchronous; flushes the pipeline and reloads the address
- in_valid  in  1  input word valid
- in_ready  out  1  encoder can accept this cycle
- in_fmt  in  3  0=R 1=I 2=S 3=B 4=U 5=J; 6,7 illegal
- in_opcode  in  7  opcode field
- in_rd, in_rs1, in_rs2  in  5 each  register fields
- in_funct3  in  3  funct3 field
- in_funct7  in  7  funct7 field (R only)
- in_imm  in  32  byte-offset immediate, sign-extended
- out_valid  out  1  encoded word valid
- out_ready  in  1  consumer accepts
- out_inst  out  32  encoded instruction (32'h0 when out_err)
- out_addr  out  32  word address of out_inst
- out_err  out  1  input rejected
- err_count  out  ERR_CNT_W  saturating count of rejected words

## Operation
- Stage 1 (S1) registers inputs on in_valid&&in_ready and computes err and the encoded word. Stage 2 (S2) is the output register.
- Illegal conditions:
  - fmt 6/7
  - opcode[1:0]!=2'b11
  - I/S: imm[31:11] not all equal
  - B: imm[31:12] not all equal, or imm[0]=1
  - U: imm[11:0]!=0
  - J: imm[31:20] not all equal, or imm[0]=1
  - R ignores in_imm.
- Field placement, all formats: opcode→[6:0]. rd→[11:7] for R/I/U/J. funct3→[14:12] and rs1→[19:15] for R/I/S/B. rs2→[24:20] for R/S/B. funct7→[31:25] for R.
- I: imm[11:0]→[31:20].
- S: imm[11:5]→[31:25], imm[4:0]→[11:7].
- B: imm[12]→31, imm[10:5]→[30:25], imm[4:1]→[11:8], imm[11]→7.
- U: imm[31:12]→[31:12].
- J: imm[20]→31, imm[10:1]→[30:21], imm[11]→20, imm[19:12]→[19:12].
- Address counter:
  - Holds the next address. out_addr is latched from it on the S1→S2 transfer.
  - Advances by 4 only on a non-error S1→S2 transfer.
  - Erroneous words carry the current address and do not advance it.
  - Wraps modulo 2^32.
- err_count increments on each out_valid&&out_ready with out_err=1 and saturates at all-ones.
- restart:
  - Clears S1/S2 valid and reloads the address to BASE_ADDR.
  - Leaves err_count unchanged.
  - Overrides any concurrent handshake; the input offered that cycle is not accepted, because in_ready=0 during restart.

## Timing
- Reset (rst_n=0, async):
  - Outputs: out_valid=0, out_inst=0, out_addr=0, out_err=0, err_count=0.
  - Internal: address=BASE_ADDR, S1 empty.
  - in_ready=0 while rst_n=0. in_ready=1 from the first clk edge after release.
- Latency: a word accepted at edge N is presented on out_valid after edge N+1.
- Throughput: one word/cycle while out_ready=1.
- Handshake: valid must not depend on ready. out_* are stable while out_valid&&!out_ready.
- in_ready = !restart && (!S1.valid || !S2.valid || out_ready). This is a registered S1 with a combinational ready back-path; no bubble on back-to-back transfers.
- Full pipeline with out_ready=0: both stages are held and in_ready=0.
- When out_ready rises, S2 drains and S1 advances on the same edge.
- Reset asserted mid-stream drops all in-flight words immediately.

## Structure
- Package inst_pkg:
  - fmt encodings FMT_R..FMT_J
  - opcode constants (OP_IMM, LOAD, JALR, STORE, BRANCH, AUIPC, LUI, JAL)
  - encoded NOP 32'h0000_0013 for benches
- One combinational sub-module inst_field_pack(fmt, fields, imm → inst, err). It is unit-testable and mirrors the decoder's bit layout.
- Pipeline, address counter, error counter and flow control live in inst_encoder.

## Test plan
- I-type: fmt=1, opcode 7'h13, rd=1, rs1=0, funct3=0, imm=-1 → out_inst=32'hFFF00093, out_addr=BASE_ADDR, err=0. The next word gets BASE_ADDR+4.
- B-type: fmt=3, opcode 7'h63, rs1=1, rs2=2, funct3=0, imm=-4 → out_inst=32'hFE208EE3. imm=3 → out_err=1, out_inst=0, address not advanced, err_count=1.
- U/J: LUI rd=5 imm=32'h12345000 → 32'h123452B7. JAL rd=1 imm=2048 → 32'h001000EF. LUI imm=32'h12345001 → err.
- Backpressure: 6 back-to-back words with out_ready toggled 1,0,0,1… → words emerge in order, none lost or duplicated, out_* stable while stalled, in_ready=0 only when both stages are full.
- restart with both stages full and in_valid=1 → out_valid=0 next cycle, the offered word is not accepted, the next accepted word gets BASE_ADDR, err_count is preserved.
- Round-trip: random legal words through inst_encoder then the immediate constructor → decoded imm32 equals the original in_imm for I/S/B/U/J. Also check err_count saturation at 255 after 300 illegal words.
